// File: rtl/cc_psr_condition_codes_pkg.sv
// Shared definitions for the PSR condition-code stage: bus widths, SPARC branch
// condition encodings and PSR image bit positions.
package cc_psr_condition_codes_pkg;

    localparam int DATAWIDTH_BUS  = 32;
    localparam int DATAWIDTH_COND = 4;

    localparam int PSR_N_BIT    = 23;
    localparam int PSR_Z_BIT    = 22;
    localparam int PSR_V_BIT    = 21;
    localparam int PSR_C_BIT    = 20;
    localparam int PSR_SVOV_BIT = 0;

    localparam logic [DATAWIDTH_COND-1:0] BN   = 4'h0;
    localparam logic [DATAWIDTH_COND-1:0] BE   = 4'h1;
    localparam logic [DATAWIDTH_COND-1:0] BLE  = 4'h2;
    localparam logic [DATAWIDTH_COND-1:0] BL   = 4'h3;
    localparam logic [DATAWIDTH_COND-1:0] BLEU = 4'h4;
    localparam logic [DATAWIDTH_COND-1:0] BCS  = 4'h5;
    localparam logic [DATAWIDTH_COND-1:0] BNEG = 4'h6;
    localparam logic [DATAWIDTH_COND-1:0] BVS  = 4'h7;
    localparam logic [DATAWIDTH_COND-1:0] BA   = 4'h8;
    localparam logic [DATAWIDTH_COND-1:0] BNE  = 4'h9;
    localparam logic [DATAWIDTH_COND-1:0] BG   = 4'hA;
    localparam logic [DATAWIDTH_COND-1:0] BGE  = 4'hB;
    localparam logic [DATAWIDTH_COND-1:0] BGU  = 4'hC;
    localparam logic [DATAWIDTH_COND-1:0] BCC  = 4'hD;
    localparam logic [DATAWIDTH_COND-1:0] BPOS = 4'hE;
    localparam logic [DATAWIDTH_COND-1:0] BVC  = 4'hF;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } icc_t;

    function automatic logic [DATAWIDTH_BUS-1:0] psr_image(input icc_t icc, input logic sticky);
        logic [DATAWIDTH_BUS-1:0] img;
        img               = '0;
        img[PSR_N_BIT]    = icc.n;
        img[PSR_Z_BIT]    = icc.z;
        img[PSR_V_BIT]    = icc.v;
        img[PSR_C_BIT]    = icc.c;
        img[PSR_SVOV_BIT] = sticky;
        return img;
    endfunction

endpackage

// File: rtl/cc_psr_condition_codes_if.sv
// ALU/microcode-facing signal bundle for the PSR stage. The master side drives
// flags and strobes; the slave side (the PSR block) returns the image and branch result.
interface cc_psr_condition_codes_if;
    import cc_psr_condition_codes_pkg::*;

    logic                      CC_PSR_negative_InLow;
    logic                      CC_PSR_zero_InLow;
    logic                      CC_PSR_overflow_InLow;
    logic                      CC_PSR_carry_InLow;
    logic                      CC_PSR_setCC_InHigh;
    logic                      CC_PSR_load_InHigh;
    logic                      CC_PSR_write_InHigh;
    logic [DATAWIDTH_BUS-1:0]  CC_PSR_data_InBUS;
    logic [DATAWIDTH_COND-1:0] CC_PSR_cond_InBUS;
    logic [DATAWIDTH_BUS-1:0]  CC_PSR_data_OutBUS;
    logic [3:0]                CC_PSR_icc_OutBUS;
    logic                      CC_PSR_branchTaken_OutHigh;
    logic                      CC_PSR_updated_OutHigh;

    modport master (
        output CC_PSR_negative_InLow, CC_PSR_zero_InLow, CC_PSR_overflow_InLow,
               CC_PSR_carry_InLow, CC_PSR_setCC_InHigh, CC_PSR_load_InHigh,
               CC_PSR_write_InHigh, CC_PSR_data_InBUS, CC_PSR_cond_InBUS,
        input  CC_PSR_data_OutBUS, CC_PSR_icc_OutBUS, CC_PSR_branchTaken_OutHigh,
               CC_PSR_updated_OutHigh
    );

    modport slave (
        input  CC_PSR_negative_InLow, CC_PSR_zero_InLow, CC_PSR_overflow_InLow,
               CC_PSR_carry_InLow, CC_PSR_setCC_InHigh, CC_PSR_load_InHigh,
               CC_PSR_write_InHigh, CC_PSR_data_InBUS, CC_PSR_cond_InBUS,
        output CC_PSR_data_OutBUS, CC_PSR_icc_OutBUS, CC_PSR_branchTaken_OutHigh,
               CC_PSR_updated_OutHigh
    );

endinterface

// File: rtl/cc_branch_condition_eval.sv
// Purely combinational SPARC integer branch-condition evaluator; shared with
// the PC-select logic so both agree on what "taken" means.
module cc_branch_condition_eval
    import cc_psr_condition_codes_pkg::*;
(
    input  icc_t                      icc,
    input  logic [DATAWIDTH_COND-1:0] cond,
    output logic                      taken
);

    logic n_xor_v;

    always_comb begin
        n_xor_v = icc.n ^ icc.v;
        taken   = 1'b0;
        case (cond)
            BN:      taken = 1'b0;
            BE:      taken = icc.z;
            BLE:     taken = icc.z | n_xor_v;
            BL:      taken = n_xor_v;
            BLEU:    taken = icc.c | icc.z;
            BCS:     taken = icc.c;
            BNEG:    taken = icc.n;
            BVS:     taken = icc.v;
            BA:      taken = 1'b1;
            BNE:     taken = ~icc.z;
            BG:      taken = ~(icc.z | n_xor_v);
            BGE:     taken = ~n_xor_v;
            BGU:     taken = ~(icc.c | icc.z);
            BCC:     taken = ~icc.c;
            BPOS:    taken = ~icc.n;
            BVC:     taken = ~icc.v;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_psr_condition_codes.sv
// PSR condition-code register: captures inverted ALU flags on committed cc ops,
// accepts direct bus writes, and drives the PSR image and branch decision.
module cc_psr_condition_codes
    import cc_psr_condition_codes_pkg::*;
(
    input  logic                     CC_PSR_CLOCK_50,
    input  logic                     CC_PSR_RESET_InLow,
    cc_psr_condition_codes_if.slave  psr_bus
);

    icc_t icc_q, icc_d;
    logic sticky_q, sticky_d;
    logic updated_q, updated_d;
    logic cc_load;
    logic unused_data_bits;

    assign cc_load = psr_bus.CC_PSR_load_InHigh & psr_bus.CC_PSR_setCC_InHigh;

    // A bus write outranks an ALU capture; the ALU flags are simply dropped then.
    always_comb begin
        icc_d     = icc_q;
        sticky_d  = sticky_q;
        updated_d = psr_bus.CC_PSR_write_InHigh | cc_load;
        if (psr_bus.CC_PSR_write_InHigh) begin
            icc_d    = icc_t'(psr_bus.CC_PSR_data_InBUS[PSR_N_BIT:PSR_C_BIT]);
            sticky_d = psr_bus.CC_PSR_data_InBUS[PSR_SVOV_BIT];
        end else if (cc_load) begin
            icc_d    = icc_t'(~{psr_bus.CC_PSR_negative_InLow, psr_bus.CC_PSR_zero_InLow,
                                psr_bus.CC_PSR_overflow_InLow, psr_bus.CC_PSR_carry_InLow});
            sticky_d = sticky_q | ~psr_bus.CC_PSR_overflow_InLow;
        end
    end

    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            icc_q     <= '0;
            sticky_q  <= 1'b0;
            updated_q <= 1'b0;
        end else begin
            icc_q     <= icc_d;
            sticky_q  <= sticky_d;
            updated_q <= updated_d;
        end
    end

    // Branches look only at the stored flags, never at the flags arriving this cycle.
    cc_branch_condition_eval u_branch_eval (
        .icc   (icc_q),
        .cond  (psr_bus.CC_PSR_cond_InBUS),
        .taken (psr_bus.CC_PSR_branchTaken_OutHigh)
    );

    assign psr_bus.CC_PSR_data_OutBUS     = psr_image(icc_q, sticky_q);
    assign psr_bus.CC_PSR_icc_OutBUS      = icc_q;
    assign psr_bus.CC_PSR_updated_OutHigh = updated_q;

    assign unused_data_bits = ^{psr_bus.CC_PSR_data_InBUS[DATAWIDTH_BUS-1:PSR_N_BIT+1],
                                psr_bus.CC_PSR_data_InBUS[PSR_C_BIT-1:PSR_SVOV_BIT+1]};

endmodule

// File: tb/tb_cc_psr_condition_codes.sv
// Randomized self-checking bench for cc_psr_condition_codes against a
// flag-level behavioural model of the PSR.
module tb_cc_psr_condition_codes;
    import cc_psr_condition_codes_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [3:0] m_icc;
    logic       m_sticky;
    logic       m_updated;

    cc_psr_condition_codes_if bus ();

    cc_psr_condition_codes dut (
        .CC_PSR_CLOCK_50    (clk),
        .CC_PSR_RESET_InLow (rst_n),
        .psr_bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Branch table: the upper half of the encoding is the complement of the lower half.
    function automatic logic model_taken(input logic [3:0] icc, input logic [3:0] cond);
        logic n, z, v, c, base;
        {n, z, v, c} = icc;
        case (cond[2:0])
            3'd0: base = 1'b0;
            3'd1: base = z;
            3'd2: base = z | (n ^ v);
            3'd3: base = n ^ v;
            3'd4: base = c | z;
            3'd5: base = c;
            3'd6: base = n;
            default: base = v;
        endcase
        return cond[3] ? ~base : base;
    endfunction

    function automatic logic [31:0] model_image();
        return {8'h00, m_icc, 19'h0, m_sticky};
    endfunction

    task automatic apply_cycle(input logic wr, input logic ld, input logic sc,
                               input logic [3:0] flags_low, input logic [31:0] data,
                               input logic [3:0] cond);
        @(negedge clk);
        bus.CC_PSR_write_InHigh   = wr;
        bus.CC_PSR_load_InHigh    = ld;
        bus.CC_PSR_setCC_InHigh   = sc;
        {bus.CC_PSR_negative_InLow, bus.CC_PSR_zero_InLow,
         bus.CC_PSR_overflow_InLow, bus.CC_PSR_carry_InLow} = flags_low;
        bus.CC_PSR_data_InBUS     = data;
        bus.CC_PSR_cond_InBUS     = cond;
        @(posedge clk);
        m_updated = wr | (ld & sc);
        if (wr) begin
            m_icc    = data[23:20];
            m_sticky = data[0];
        end else if (ld && sc) begin
            m_icc    = ~flags_low;
            m_sticky = m_sticky | ~flags_low[1];
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.CC_PSR_write_InHigh = 1'b0;
        bus.CC_PSR_load_InHigh  = 1'b0;
        bus.CC_PSR_setCC_InHigh = 1'b0;
        {bus.CC_PSR_negative_InLow, bus.CC_PSR_zero_InLow,
         bus.CC_PSR_overflow_InLow, bus.CC_PSR_carry_InLow} = 4'hF;
        bus.CC_PSR_data_InBUS = 32'h0;
        bus.CC_PSR_cond_InBUS = 4'h8;
        m_icc = 4'h0; m_sticky = 1'b0; m_updated = 1'b0;
        #12;
        checks++;
        if (bus.CC_PSR_data_OutBUS !== 32'h0) begin
            failures++; $display("[TB] FAIL reset_data got=%h exp=%h", bus.CC_PSR_data_OutBUS, 32'h0);
        end
        checks++;
        if (bus.CC_PSR_icc_OutBUS !== 4'h0) begin
            failures++; $display("[TB] FAIL reset_icc got=%b exp=0000", bus.CC_PSR_icc_OutBUS);
        end
        checks++;
        if (bus.CC_PSR_updated_OutHigh !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_updated got=%b exp=0", bus.CC_PSR_updated_OutHigh);
        end
        checks++;
        if (bus.CC_PSR_branchTaken_OutHigh !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_ba got=%b exp=1", bus.CC_PSR_branchTaken_OutHigh);
        end
        bus.CC_PSR_cond_InBUS = 4'h1;
        #1;
        checks++;
        if (bus.CC_PSR_branchTaken_OutHigh !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_be got=%b exp=0", bus.CC_PSR_branchTaken_OutHigh);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addcc();
        apply_cycle(1'b0, 1'b1, 1'b1, 4'b0101, 32'h0, 4'h7);
        checks++;
        if (bus.CC_PSR_icc_OutBUS !== 4'b1010) begin
            failures++; $display("[TB] FAIL addcc_icc got=%b exp=1010", bus.CC_PSR_icc_OutBUS);
        end
        checks++;
        if (bus.CC_PSR_data_OutBUS !== 32'h00A0_0001) begin
            failures++; $display("[TB] FAIL addcc_data got=%h exp=00a00001", bus.CC_PSR_data_OutBUS);
        end
        checks++;
        if (bus.CC_PSR_updated_OutHigh !== 1'b1) begin
            failures++; $display("[TB] FAIL addcc_updated got=%b exp=1", bus.CC_PSR_updated_OutHigh);
        end
        checks++;
        if (bus.CC_PSR_branchTaken_OutHigh !== 1'b1) begin
            failures++; $display("[TB] FAIL addcc_bvs got=%b exp=1", bus.CC_PSR_branchTaken_OutHigh);
        end
        bus.CC_PSR_cond_InBUS = 4'h3;
        #1;
        checks++;
        if (bus.CC_PSR_branchTaken_OutHigh !== 1'b0) begin
            failures++; $display("[TB] FAIL addcc_bl got=%b exp=0", bus.CC_PSR_branchTaken_OutHigh);
        end
        apply_cycle(1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 4'h3);
        checks++;
        if (bus.CC_PSR_updated_OutHigh !== 1'b0) begin
            failures++; $display("[TB] FAIL addcc_pulse_end got=%b exp=0", bus.CC_PSR_updated_OutHigh);
        end
    endtask

    task automatic test_non_cc();
        apply_cycle(1'b0, 1'b1, 1'b0, 4'b1011, 32'h0, 4'h0);
        checks++;
        if (bus.CC_PSR_icc_OutBUS !== 4'b1010) begin
            failures++; $display("[TB] FAIL noncc_icc got=%b exp=1010", bus.CC_PSR_icc_OutBUS);
        end
        checks++;
        if (bus.CC_PSR_updated_OutHigh !== 1'b0) begin
            failures++; $display("[TB] FAIL noncc_updated got=%b exp=0", bus.CC_PSR_updated_OutHigh);
        end
    endtask

    task automatic test_priority();
        apply_cycle(1'b1, 1'b1, 1'b1, 4'b0000, 32'h0040_0000, 4'h1);
        checks++;
        if (bus.CC_PSR_icc_OutBUS !== 4'b0100) begin
            failures++; $display("[TB] FAIL prio_icc got=%b exp=0100", bus.CC_PSR_icc_OutBUS);
        end
        checks++;
        if (bus.CC_PSR_data_OutBUS !== 32'h0040_0000) begin
            failures++; $display("[TB] FAIL prio_data got=%h exp=00400000", bus.CC_PSR_data_OutBUS);
        end
        checks++;
        if (bus.CC_PSR_updated_OutHigh !== 1'b1) begin
            failures++; $display("[TB] FAIL prio_updated got=%b exp=1", bus.CC_PSR_updated_OutHigh);
        end
    endtask

    task automatic test_branch_sweep();
        for (int val = 0; val < 16; val++) begin
            apply_cycle(1'b1, 1'b0, 1'b0, 4'hF, {8'h00, val[3:0], 20'h0}, 4'h0);
            apply_cycle(1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 4'h0);
            for (int cond = 0; cond < 16; cond++) begin
                bus.CC_PSR_cond_InBUS = cond[3:0];
                #1;
                checks++;
                if (bus.CC_PSR_branchTaken_OutHigh !== model_taken(val[3:0], cond[3:0])) begin
                    failures++;
                    $display("[TB] FAIL sweep icc=%b cond=%b got=%b exp=%b", val[3:0], cond[3:0],
                             bus.CC_PSR_branchTaken_OutHigh, model_taken(val[3:0], cond[3:0]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            apply_cycle(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 32'h0, 4'($urandom_range(0, 15)));
            checks++;
            if (bus.CC_PSR_updated_OutHigh !== 1'b1 || bus.CC_PSR_icc_OutBUS !== m_icc) begin
                failures++;
                $display("[TB] FAIL b2b cycle=%0d got upd=%b icc=%b exp upd=1 icc=%b", i,
                         bus.CC_PSR_updated_OutHigh, bus.CC_PSR_icc_OutBUS, m_icc);
            end
        end
    endtask

    task automatic test_random();
        logic wr, ld, sc;
        for (int i = 0; i < 300; i++) begin
            wr = ($urandom_range(0, 3) == 0);
            ld = $urandom_range(0, 1) == 1;
            sc = $urandom_range(0, 1) == 1;
            apply_cycle(wr, ld, sc, 4'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(0, 15)));
            checks++;
            if (bus.CC_PSR_data_OutBUS !== model_image() || bus.CC_PSR_icc_OutBUS !== m_icc ||
                bus.CC_PSR_updated_OutHigh !== m_updated ||
                bus.CC_PSR_branchTaken_OutHigh !== model_taken(m_icc, bus.CC_PSR_cond_InBUS)) begin
                failures++;
                $display("[TB] FAIL random cycle=%0d got data=%h upd=%b tk=%b exp data=%h upd=%b tk=%b",
                         i, bus.CC_PSR_data_OutBUS, bus.CC_PSR_updated_OutHigh,
                         bus.CC_PSR_branchTaken_OutHigh, model_image(), m_updated,
                         model_taken(m_icc, bus.CC_PSR_cond_InBUS));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        apply_cycle(1'b0, 1'b1, 1'b1, 4'b0110, 32'h0, 4'h6);
        @(negedge clk);
        bus.CC_PSR_load_InHigh  = 1'b1;
        bus.CC_PSR_setCC_InHigh = 1'b1;
        {bus.CC_PSR_negative_InLow, bus.CC_PSR_zero_InLow,
         bus.CC_PSR_overflow_InLow, bus.CC_PSR_carry_InLow} = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.CC_PSR_data_OutBUS !== 32'h0 || bus.CC_PSR_icc_OutBUS !== 4'h0 ||
            bus.CC_PSR_updated_OutHigh !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_async got data=%h icc=%b upd=%b exp 0", bus.CC_PSR_data_OutBUS,
                     bus.CC_PSR_icc_OutBUS, bus.CC_PSR_updated_OutHigh);
        end
        m_icc = 4'h0; m_sticky = 1'b0; m_updated = 1'b0;
        @(negedge clk);
        bus.CC_PSR_load_InHigh  = 1'b0;
        bus.CC_PSR_setCC_InHigh = 1'b0;
        #2;
        rst_n = 1'b1;
        apply_cycle(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h1);
        checks++;
        if (bus.CC_PSR_icc_OutBUS !== 4'h0 || bus.CC_PSR_updated_OutHigh !== 1'b0 ||
            bus.CC_PSR_data_OutBUS !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midreset_after got icc=%b upd=%b data=%h exp 0", bus.CC_PSR_icc_OutBUS,
                     bus.CC_PSR_updated_OutHigh, bus.CC_PSR_data_OutBUS);
        end
        apply_cycle(1'b0, 1'b1, 1'b1, 4'b1110, 32'h0, 4'h7);
        checks++;
        if (bus.CC_PSR_icc_OutBUS !== 4'b0001 || bus.CC_PSR_data_OutBUS !== 32'h0010_0000) begin
            failures++;
            $display("[TB] FAIL midreset_reload got icc=%b data=%h exp icc=0001 data=00100000",
                     bus.CC_PSR_icc_OutBUS, bus.CC_PSR_data_OutBUS);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_addcc();
        test_non_cc();
        test_priority();
        test_branch_sweep();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc_psr_condition_codes.md
# cc_psr_condition_codes

Processor status / condition-code stage directly downstream of the ALU. Captures the ALU's active-low N/Z/V/C flags into an integer-condition-code (icc) register whenever the ALU reports a condition-code-setting operation and the microcontroller commits the result. Exposes a 32-bit PSR image on the data bus and evaluates the 4-bit branch condition field against the stored flags for the branch-control logic.

## Interface
- DATAWIDTH_BUS, 32, data bus / PSR image width
- DATAWIDTH_COND, 4, branch condition field width

- CC_PSR_CLOCK_50  in  1  system clock, rising edge
- CC_PSR_RESET_InLow  in  1  asynchronous, active-low reset
- CC_PSR_negative_InLow  in  1  ALU N flag, active-low
- CC_PSR_zero_InLow  in  1  ALU Z flag, active-low
- CC_PSR_overflow_InLow  in  1  ALU V flag, active-low
- CC_PSR_carry_InLow  in  1  ALU C flag, active-low
- CC_PSR_setCC_InHigh  in  1  ALU Set_Conditions_Code (1 = cc-setting op selected)
- CC_PSR_load_InHigh  in  1  microcode strobe: ALU result commits this cycle
- CC_PSR_write_InHigh  in  1  direct PSR write from bus
- CC_PSR_data_InBUS  in  DATAWIDTH_BUS  write data; [23:20]=N,Z,V,C, [0]=sticky V
- CC_PSR_cond_InBUS  in  DATAWIDTH_COND  branch condition (IR[28:25])
- CC_PSR_data_OutBUS  out  DATAWIDTH_BUS  PSR image, same layout, other bits 0
- CC_PSR_icc_OutBUS  out  4  stored {N,Z,V,C}, active-high
- CC_PSR_branchTaken_OutHigh  out  1  condition true on stored flags
- CC_PSR_updated_OutHigh  out  1  one-cycle pulse after any icc change

## Operation
- Flag inputs inverted on capture; storage and outputs active-high.
- Update sources, priority per rising edge:
  - write=1: icc <= data_InBUS[23:20]; sticky <= data_InBUS[0].
  - else load=1 and setCC=1: icc <= ~{N,Z,V,C}_InLow; sticky <= sticky | ~overflow_InLow.
  - else hold. load=1 with setCC=0 (non-cc ALU op) never changes icc.
- updated register <= 1 in any cycle where a write or cc-load edge occurs (even if value unchanged), else 0.
- branchTaken combinational from stored icc (never from incoming flags), SPARC icc encoding:
  - 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V; 0100 C|Z; 0101 C; 0110 N; 0111 V
  - 1000 always; 1001 ~Z; 1010 ~(Z|(N^V)); 1011 ~(N^V); 1100 ~(C|Z); 1101 ~C; 1110 ~N; 1111 ~V
- data_OutBUS = {8'b0, N, Z, V, C, 19'b0, sticky}.

## Timing
- Reset (async assert, sync-safe deassert): icc=0000, sticky=0, updated=0, data_OutBUS=0; branchTaken follows cond on zero flags (e.g., 1000 → 1, 0001 → 0).
- Capture latency 1 cycle: flags sampled at edge k, visible on icc/data_OutBUS/branchTaken after edge k; updated high for cycle k+1 only.
- A branch evaluated in the same cycle as a cc-load sees pre-update flags; microcode inserts one cycle between cc-setting op and dependent branch.
- Simultaneous write and load+setCC: write wins, ALU flags discarded, sticky not OR'd.
- Reset asserted mid-cycle clears all state immediately; pending strobe is lost; no updated pulse after deassertion.
- Back-to-back loads: each edge captures; updated stays high continuously.

## Structure
- Shared package: branch condition constants (BN…BVC, 4'h0–4'hF), PSR bit positions (N=23, Z=22, V=21, C=20, SVOV=0).
- Sub-module cc_branch_condition_eval: purely combinational {icc, cond} → taken; instantiated once; reused by the PC-select logic.

## Test plan
- Reset: RESET_InLow=0 → data_OutBUS=32'h0000_0000, icc=0000, updated=0; cond=1000 → branchTaken=1, cond=0001 → 0.
- ADDCC 0x7FFFFFFF+1: flags in N=0,Z=1,V=0,C=1 (active-low), load=1, setCC=1 → next cycle icc=1010, data_OutBUS=32'h00A0_0001, updated=1 one cycle; cond=0111 → 1, cond=0011 → 0.
- Non-cc ADD: load=1, setCC=0, zero_InLow=0 → icc unchanged, updated=0.
- Priority: write=1 with data_InBUS=32'h0040_0000 and load=setCC=1, all flags active → icc=0100, sticky=0, data_OutBUS=32'h0040_0000.
- Branch sweep: preload icc via write to each of 16 values, step cond 0–15 → branchTaken matches table for all 256 combinations.
- Reset mid-op: assert reset between two loads → outputs 0 asynchronously; after release, icc=0000 until next strobe.
